// File: rtl/sha256_sched_ctrl.sv
// sha256_sched_ctrl
// Sequencer for the SHA-256 message-schedule unit. It loads the 16 message
// words of a block, then steps the schedule unit through the expansion rounds.
// Each W[t] is forwarded to the compression rounds through a single output
// register with valid/ready back-pressure. The block also owns the round
// counter that the rest of the hash core follows.
//
// Optional build macro:
//   SCHED_BLKCNT_EN - adds output BLK_CNT, a wrapping count of completed blocks.
module sha256_sched_ctrl #(
    parameter int ROUNDS    = 64,   // schedule words per block, 17..64
    parameter int BLK_CNT_W = 16    // completed-block counter width
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic [31:0] M_DATA,
    input  logic        M_VLD,
    output logic        M_RDY,
    output logic [5:0]  I,
    output logic [31:0] D_IN,
    output logic        STEP,
    input  logic [31:0] D_OUT,
    output logic [31:0] W_T,
    output logic [5:0]  T,
    output logic        W_VLD,
    input  logic        W_RDY,
    output logic        BUSY,
    output logic        DONE
`ifdef SCHED_BLKCNT_EN
    ,
    output logic [BLK_CNT_W-1:0] BLK_CNT
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_EXPAND = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

    localparam logic [5:0] LAST_T    = 6'(ROUNDS - 1);
    localparam logic [5:0] LAST_LOAD = 6'd15;

    state_t      state_q;
    logic [5:0]  cnt_q;
    logic [31:0] w_t_q;
    logic [5:0]  t_q;
    logic        w_vld_q;
    logic        slot_free;
    logic        step_c;
    logic        done_c;

    // Handshake decode: the output register may take a new word when it is
    // empty or its current word is being consumed in this same cycle.
    always_comb begin
        slot_free = !w_vld_q || W_RDY;
        M_RDY     = 1'b0;
        D_IN      = 32'd0;
        step_c    = 1'b0;
        done_c    = 1'b0;
        case (state_q)
            S_LOAD: begin
                M_RDY  = slot_free;
                D_IN   = M_DATA;
                step_c = M_VLD && slot_free;
            end
            S_EXPAND: begin
                step_c = slot_free;
            end
            S_DRAIN: begin
                done_c = !w_vld_q || (W_RDY && (t_q == LAST_T));
            end
            default: ;
        endcase
    end

    // Sequencer FSM and round counter; cnt doubles as the schedule index I.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= 6'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (START) begin
                        state_q <= S_LOAD;
                        cnt_q   <= 6'd0;
                    end
                end
                S_LOAD: begin
                    if (step_c) begin
                        cnt_q <= cnt_q + 6'd1;
                        if (cnt_q == LAST_LOAD) begin
                            state_q <= S_EXPAND;
                        end
                    end
                end
                S_EXPAND: begin
                    if (step_c) begin
                        if (cnt_q == LAST_T) begin
                            cnt_q   <= 6'd0;
                            state_q <= S_DRAIN;
                        end else begin
                            cnt_q <= cnt_q + 6'd1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (done_c) begin
                        cnt_q   <= 6'd0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // W[t] output register: captures the schedule unit result on every step,
    // empties when the round function takes the word and nothing replaces it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            w_t_q   <= 32'd0;
            t_q     <= 6'd0;
            w_vld_q <= 1'b0;
        end else if (step_c) begin
            w_t_q   <= D_OUT;
            t_q     <= cnt_q;
            w_vld_q <= 1'b1;
        end else if (W_RDY) begin
            w_vld_q <= 1'b0;
        end
    end

`ifdef SCHED_BLKCNT_EN
    logic [BLK_CNT_W-1:0] blk_cnt_q;

    // Completed-block counter, wraps naturally at all-ones.
    always_ff @(posedge CLK) begin
        if (RST) begin
            blk_cnt_q <= '0;
        end else if (done_c) begin
            blk_cnt_q <= blk_cnt_q + 1'b1;
        end
    end

    assign BLK_CNT = blk_cnt_q;
`endif

    assign I     = cnt_q;
    assign STEP  = step_c;
    assign DONE  = done_c;
    assign W_T   = w_t_q;
    assign T     = t_q;
    assign W_VLD = w_vld_q;
    assign BUSY  = (state_q != S_IDLE);

endmodule
